// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle unsigned multiply/divide unit for the RISC16 datapath.
// Takes operands from the register-file read ports (R, S) and writes one result
// back through the write port (W, W_adr, we). Each op iterates one bit per cycle.
module mul_div_unit #(
  parameter int WIDTH = 16,
  parameter int ADR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  input  logic [ADR_W-1:0] D_adr,
  output logic             busy,
  output logic             done,
  output logic             we,
  output logic [WIDTH-1:0] W,
  output logic [ADR_W-1:0] W_adr
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  // opnd holds the multiplicand (MUL) or the divisor (DIV).
  logic [WIDTH-1:0] opnd_q, opnd_d;
  // lo holds multiplier -> product low half (MUL) or dividend -> quotient (DIV).
  logic [WIDTH-1:0] lo_q, lo_d;
  // acc holds the product high half (MUL) or the partial remainder (DIV).
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [ADR_W-1:0] w_adr_q, w_adr_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] lo_step;

  // One iteration of shift-add multiply or restoring divide, based on the latched op.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, opnd_q});
    acc_step  = acc_q;
    lo_step   = lo_q;
    if (op_q[1]) begin
      acc_step = div_fits ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
      lo_step  = {lo_q[WIDTH-2:0], div_fits};
    end else begin
      acc_step = mul_sum[WIDTH:1];
      lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Next-state logic: accept in IDLE, iterate in RUN, publish the result on entry to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    adr_d   = adr_q;
    opnd_d  = opnd_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    w_d     = w_q;
    w_adr_d = w_adr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          adr_d  = D_adr;
          opnd_d = op[1] ? S : R;
          lo_d   = op[1] ? R : S;
          acc_d  = '0;
          cnt_d  = '0;
          if (op[1] && (S == '0)) begin
            // Divide by zero skips iteration: quotient all ones, remainder is the dividend.
            w_d     = op[0] ? R : '1;
            w_adr_d = D_adr;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = acc_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          w_d     = op_q[0] ? acc_step : lo_step;
          w_adr_d = adr_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      adr_q   <= '0;
      opnd_q  <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      w_q     <= '0;
      w_adr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      adr_q   <= adr_d;
      opnd_q  <= opnd_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      w_adr_q <= w_adr_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign we    = done;
  assign W     = w_q;
  assign W_adr = w_adr_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle unsigned 16-bit multiply/divide unit for the RISC16 datapath. It sits directly downstream of the register file's two read ports (R, S) and feeds the result back into the register file write port (W, W_adr, we). It executes MUL-low, MUL-high, DIV-quotient and DIV-remainder ops. Each op is iterative: one bit per cycle, 16 iterations.

## Interface
- WIDTH, 16: operand/result width; iteration count equals WIDTH.
- ADR_W, 3: register address width (8 registers).

- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; returns block to IDLE.
- start  input  1  request; sampled only while busy=0.
- op  input  2  00 MUL low, 01 MUL high, 10 DIV quotient, 11 DIV remainder.
- R  input  WIDTH  operand A (multiplicand / dividend), from register-file read path 1.
- S  input  WIDTH  operand B (multiplier / divisor), from register-file read path 2.
- D_adr  input  ADR_W  destination register for the result.
- busy  output  1  high from acceptance cycle through the DONE cycle inclusive.
- done  output  1  one-cycle pulse, result valid.
- we  output  1  register-file write enable; identical to done.
- W  output  WIDTH  result data to register-file write port.
- W_adr  output  ADR_W  destination address to register-file write port.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch R, S, op, D_adr. Clear counter and accumulator.
  - Divide op with S=0: go to DONE.
  - Otherwise: go to RUN.
- RUN: one iteration per cycle; counter 0..WIDTH-1. After iteration WIDTH-1, go to DONE.
- DONE: done=we=1 for one cycle. W and W_adr take the result and latched D_adr. Return to IDLE.
- start while busy=1 is ignored; there is no queuing. A new start is accepted in the cycle after DONE.
- Multiply: shift-add into a 2*WIDTH-bit product, multiplier examined LSB first.
  - op 00 returns product[15:0].
  - op 01 returns product[31:16].
- Divide: restoring division, dividend bits shifted in MSB first, WIDTH-bit quotient and remainder.
  - op 10 returns quotient.
  - op 11 returns remainder.
- Divide by zero:
  - quotient = 16'hFFFF.
  - remainder = dividend.
  - No RUN phase.
- Operands are unsigned. No overflow flag. The MUL-low result is the product mod 2^16.
- Operands are latched at acceptance. R/S/D_adr changes after acceptance do not affect the result.

## Timing
- Reset values: busy=0, done=0, we=0, W=0, W_adr=0. State=IDLE; internal registers cleared.
- Latency for normal ops: start accepted at edge N, then RUN for edges N+1..N+16, and done/we are high in the cycle after edge N+16. That is 17 cycles from acceptance; throughput is one op per 18 cycles.
- Latency for divide-by-zero: done/we are high in the cycle after the acceptance edge (1 cycle).
- W and W_adr hold their last value outside DONE. The consumer qualifies them with we.
- reset=1 in any state: the next edge forces IDLE and no we pulse is produced. reset has priority over start in the same cycle.
- busy goes high the cycle after acceptance and stays high through the DONE cycle.

## Test plan
- MUL low, R=3, S=5, D_adr=2: W=0x000F, W_adr=2, we pulses once, 17 cycles after accept.
- MUL high/low, R=S=0xFFFF: op 01 gives W=0xFFFE; op 00 gives W=0x0001.
- DIV, R=100, S=7: op 10 gives W=0x000E; op 11 gives W=0x0002; both at 17-cycle latency.
- Divide by zero, R=0x1234, S=0:
  - op 10 gives W=0xFFFF.
  - op 11 gives W=0x1234.
  - done arrives 1 cycle after accept.
- start re-asserted with new operands during RUN: ignored; only the first result appears. Change R/S mid-RUN: the result is unaffected.
- reset asserted at RUN iteration 8: busy=0 and we=0 next cycle, and no we pulse follows. A new MUL 2*2 then gives W=4 normally.
